// File: rtl/pmem_arbiter.sv
// Shares the single pmem cacheline port between icache and dcache.
// D has fixed priority; I is forced after STARVE_LIMIT D grants.
module pmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int OFF = $clog2(LINE_W / 8);
  localparam int CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req, i_starved;
  logic grant_i, grant_d;

  assign i_req     = i_mem_read;
  assign d_req     = d_mem_read | d_mem_write;
  assign i_starved = i_req && (starve_q == CW'(STARVE_LIMIT));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_starved)  grant_i = 1'b1;
        else if (d_req) grant_d = 1'b1;
        else if (i_req) grant_i = 1'b1;
        if (grant_i || !i_req)
          starve_d = '0;
        else if (starve_q != CW'(STARVE_LIMIT))
          starve_d = starve_q + CW'(1);
        if (grant_i) begin
          state_d    = I_BUSY;
          mem_read_d = 1'b1;
          addr_d     = i_mem_address & LINE_MASK;
        end
        if (grant_d) begin
          state_d     = D_BUSY;
          mem_read_d  = !d_mem_write;
          mem_write_d = d_mem_write;
          addr_d      = d_mem_address & LINE_MASK;
          if (d_mem_write) wdata_d = d_mem_wdata;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      // gap cycle masks a request dropped one cycle late
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign i_mem_resp  = (state_q == I_BUSY) && mem_resp;
  assign d_mem_resp  = (state_q == D_BUSY) && mem_resp;

  a_d_rw_excl: assert property (
    @(posedge clk) disable iff (!rst)
    !(d_mem_read && d_mem_write)
  );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomised bench for pmem_arbiter with a transaction-level model
// of the grant rules, starvation guard and response routing.
module tb_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_wdata;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  always #5 clk = ~clk;

  pmem_arbiter #(
    .ADDR_W(AW),
    .LINE_W(LW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_mem_read(i_mem_read),
    .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata),
    .d_mem_resp(d_mem_resp),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [LW-1:0] got,
                       logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // reference model state
  bit            m_busy, m_gap, m_own_d, m_write;
  int            m_starve;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  // agent knobs
  bit            i_go, d_go, d_go_write, spur_en, hold_late;
  bit            i_late, prev_strobe;
  logic [AW-1:0] i_next, d_next;
  logic [LW-1:0] d_next_wdata;
  int            lat_fix, pm_cnt;
  int            i_pulses, d_pulses;
  logic [AW-1:0] tx_log[$];

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cycle();
    bit            pi, pd, pw, pr, fin_i, fin_d, gd;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] dwd;
    pi  = i_mem_read;
    pd  = d_mem_read || d_mem_write;
    pw  = d_mem_write;
    pr  = mem_resp;
    ia  = i_mem_address;
    da  = d_mem_address;
    dwd = d_mem_wdata;
    fin_i = 0;
    fin_d = 0;
    @(posedge clk);
    #1;
    if (m_busy) begin
      if (pr) begin
        m_busy = 0;
        m_gap  = 1;
        fin_i  = !m_own_d;
        fin_d  = m_own_d;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (pi || pd) begin
      gd      = pd && !(pi && m_starve == SL);
      m_busy  = 1;
      m_own_d = gd;
      m_write = gd && pw;
      m_addr  = (gd ? da : ia) & 32'hffff_ffe0;
      if (m_write) m_wdata = dwd;
      if (gd && pi) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else m_starve = 0;
      pm_cnt = (lat_fix > 0) ? lat_fix : $urandom_range(1, 6);
    end else begin
      m_starve = 0;
    end
    check("mem_read", LW'(mem_read), LW'(m_busy && !m_write));
    check("mem_write", LW'(mem_write), LW'(m_busy && m_write));
    if (m_busy) begin
      check("mem_address", LW'(mem_address), LW'(m_addr));
      if (m_write) check("mem_wdata", mem_wdata, m_wdata);
    end
    if ((mem_read || mem_write) && !prev_strobe)
      tx_log.push_back(mem_address);
    prev_strobe = mem_read || mem_write;
    // icache agent
    if (fin_i && !hold_late) i_mem_read = 0;
    else if (fin_i) i_late = 1;
    else if (i_late) begin
      i_late = 0;
      i_mem_read = 0;
    end else if (i_mem_read && m_busy && !m_own_d)
      i_mem_address = $urandom;
    if (!i_mem_read && i_go) begin
      i_mem_read    = 1;
      i_mem_address = i_next;
    end
    // dcache agent
    if (fin_d) begin
      d_mem_read  = 0;
      d_mem_write = 0;
    end else if ((d_mem_read || d_mem_write) && m_busy && m_own_d) begin
      d_mem_address = $urandom;
      d_mem_wdata   = rnd_line();
    end
    if (!(d_mem_read || d_mem_write) && d_go) begin
      d_mem_write   = d_go_write;
      d_mem_read    = !d_go_write;
      d_mem_address = d_next;
      d_mem_wdata   = d_next_wdata;
    end
    // pmem
    mem_rdata = rnd_line();
    mem_resp  = 0;
    if (m_busy) begin
      pm_cnt--;
      if (pm_cnt == 0) mem_resp = 1;
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      mem_resp = 1;
    end
    #1;
    check("i_mem_resp", LW'(i_mem_resp),
          LW'(m_busy && !m_own_d && mem_resp));
    check("d_mem_resp", LW'(d_mem_resp),
          LW'(m_busy && m_own_d && mem_resp));
    check("i_mem_rdata", i_mem_rdata, mem_rdata);
    check("d_mem_rdata", d_mem_rdata, mem_rdata);
    if (i_mem_resp) i_pulses++;
    if (d_mem_resp) d_pulses++;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic chk_zero_outs(string tag);
    check({tag, "_rd"}, LW'(mem_read), '0);
    check({tag, "_wr"}, LW'(mem_write), '0);
    check({tag, "_addr"}, LW'(mem_address), '0);
    check({tag, "_wdata"}, mem_wdata, '0);
    check({tag, "_iresp"}, LW'(i_mem_resp), '0);
    check({tag, "_dresp"}, LW'(d_mem_resp), '0);
  endtask

  initial begin
    int            st, ip, budget, icnt;
    logic [LW-1:0] wpat;
    rst = 0;
    i_mem_read = 0; i_mem_address = '0;
    d_mem_read = 0; d_mem_write = 0;
    d_mem_address = '0; d_mem_wdata = '0;
    mem_rdata = '0; mem_resp = 1;
    m_busy = 0; m_gap = 0; m_own_d = 0; m_write = 0;
    m_starve = 0; m_addr = '0; m_wdata = '0;
    i_go = 0; d_go = 0; d_go_write = 0; spur_en = 0;
    hold_late = 0; i_late = 0; prev_strobe = 0;
    i_next = '0; d_next = '0; d_next_wdata = '0;
    lat_fix = 5; pm_cnt = 0; i_pulses = 0; d_pulses = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    mem_resp = 0;
    rst = 1;
    #1;

    // single I read, latency 5
    st = tx_log.size();
    ip = i_pulses;
    i_next = 32'h0000_1064;
    i_go = 1;
    cycle();
    i_go = 0;
    cycle();
    check("t1_strobe", LW'(mem_read), LW'(1));
    check("t1_addr", LW'(mem_address), LW'(32'h0000_1060));
    run(12);
    check("t1_ipulses", LW'(i_pulses - ip), LW'(1));
    check("t1_dpulses", LW'(d_pulses), LW'(0));
    check("t1_ntx", LW'(tx_log.size() - st), LW'(1));

    // simultaneous I and D: D first
    st = tx_log.size();
    i_next = 32'h0000_3000;
    d_next = 32'h0000_4000;
    d_go_write = 0;
    i_go = 1;
    d_go = 1;
    cycle();
    i_go = 0;
    d_go = 0;
    run(30);
    check("t2_ntx", LW'(tx_log.size() - st), LW'(2));
    if (tx_log.size() >= st + 2) begin
      check("t2_first", LW'(tx_log[st]), LW'(32'h0000_4000));
      check("t2_second", LW'(tx_log[st+1]), LW'(32'h0000_3000));
    end

    // D writeback, wdata latched
    wpat = {16'hDEAD, 224'h0, 16'hBEEF};
    wpat[LW-17:16] = {14{16'h5A5A}};
    d_next = 32'h0000_0080;
    d_next_wdata = wpat;
    d_go_write = 1;
    d_go = 1;
    cycle();
    d_go = 0;
    cycle();
    check("t3_write", LW'(mem_write), LW'(1));
    check("t3_addr", LW'(mem_address), LW'(32'h0000_0080));
    check("t3_wdata0", mem_wdata, wpat);
    run(2);
    check("t3_wdata_mid", mem_wdata, wpat);
    run(10);
    d_go_write = 0;

    // starvation guard
    lat_fix = 2;
    st = tx_log.size();
    i_next = 32'h0000_9000;
    i_go = 1;
    d_go = 1;
    budget = 300;
    while (tx_log.size() < st + 10 && budget > 0) begin
      d_next = 32'h0000_2000 + ($urandom_range(0, 255) << 5);
      cycle();
      budget--;
    end
    i_go = 0;
    d_go = 0;
    check("t4_budget", LW'(tx_log.size() >= st + 10), LW'(1));
    if (tx_log.size() >= st + 10) begin
      icnt = 0;
      for (int k = 0; k < 4; k++)
        if (tx_log[st+k] == 32'h0000_9000) icnt++;
      check("t4_first_ds", LW'(icnt), LW'(0));
      check("t4_i_at4", LW'(tx_log[st+4]), LW'(32'h0000_9000));
      check("t4_i_at9", LW'(tx_log[st+9]), LW'(32'h0000_9000));
    end
    run(20);

    // late deassert masked by the gap cycle
    hold_late = 1;
    st = tx_log.size();
    ip = i_pulses;
    i_next = 32'h0000_5040;
    i_go = 1;
    cycle();
    i_go = 0;
    run(20);
    hold_late = 0;
    check("t6_ntx", LW'(tx_log.size() - st), LW'(1));
    check("t6_ipulses", LW'(i_pulses - ip), LW'(1));

    // async reset mid D_BUSY
    lat_fix = 10;
    d_next = 32'h0000_0100;
    d_next_wdata = rnd_line();
    d_go_write = 1;
    d_go = 1;
    cycle();
    d_go = 0;
    run(2);
    check("t5_busy", LW'(mem_write), LW'(1));
    mem_resp = 1;
    rst = 0;
    #1;
    chk_zero_outs("t5");
    i_mem_read = 0;
    d_mem_read = 0;
    d_mem_write = 0;
    mem_resp = 0;
    d_go_write = 0;
    m_busy = 0; m_gap = 0; m_starve = 0;
    prev_strobe = 0; i_late = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    lat_fix = 3;
    i_next = 32'h0000_7000;
    i_go = 1;
    cycle();
    i_go = 0;
    cycle();
    check("t5_i_rd", LW'(mem_read), LW'(1));
    check("t5_i_addr", LW'(mem_address), LW'(32'h0000_7000));
    run(10);

    // randomised traffic
    lat_fix = 0;
    spur_en = 1;
    for (int n = 0; n < 3000; n++) begin
      i_go = ($urandom_range(0, 3) == 0);
      d_go = ($urandom_range(0, 2) != 0);
      d_go_write = $urandom_range(0, 1);
      i_next = $urandom;
      d_next = $urandom;
      d_next_wdata = rnd_line();
      cycle();
    end
    i_go = 0;
    d_go = 0;
    run(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
